// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: protocol bytes, controller states and
// the bit layout of the first movement-packet byte.
package mouse_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] DEV_ID     = 8'h00;

  localparam int unsigned PB_LEFT   = 0;
  localparam int unsigned PB_RIGHT  = 1;
  localparam int unsigned PB_MIDDLE = 2;
  localparam int unsigned PB_SYNC   = 3;
  localparam int unsigned PB_XSIGN  = 4;
  localparam int unsigned PB_YSIGN  = 5;
  localparam int unsigned PB_XOVF   = 6;
  localparam int unsigned PB_YOVF   = 7;

  typedef enum logic [3:0] {
    ST_RST_SEND,
    ST_RST_ACK,
    ST_BAT,
    ST_ID,
    ST_EN_SEND,
    ST_EN_ACK,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_FAIL
  } state_t;

  // Byte the device must answer with while the controller sits in state s.
  function automatic logic [7:0] expected_rsp(input state_t s);
    case (s)
      ST_RST_ACK: return RSP_ACK;
      ST_BAT:     return RSP_BAT_OK;
      ST_ID:      return DEV_ID;
      ST_EN_ACK:  return RSP_ACK;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Byte-level link between the mouse controller and the PS/2 pin transceiver.
interface ps2_mouse_ctrl_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_err;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  modport master (
    output tx_byte, tx_start,
    input  tx_busy, tx_err, rx_byte, rx_valid, rx_err
  );

  modport slave (
    input  tx_byte, tx_start,
    output tx_busy, tx_err, rx_byte, rx_valid, rx_err
  );
endinterface

// File: rtl/ps2_cursor_accum.sv
// Cursor position registers: applies a 9-bit PS/2 displacement with
// overflow masking, Y inversion and clamping to the visible area.
module ps2_cursor_accum #(
  parameter int unsigned X_MAX  = 639,
  parameter int unsigned Y_MAX  = 479,
  parameter int unsigned X_INIT = 320,
  parameter int unsigned Y_INIT = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       commit,
  input  logic [8:0] dx9,
  input  logic [8:0] dy9,
  input  logic       x_ovf,
  input  logic       y_ovf,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y
);

  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);

  logic signed [11:0] dx, dy, nx, ny;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [9:0] hi);
    if (v < 0) return '0;
    else if (v > $signed({2'b00, hi})) return hi;
    else return v[9:0];
  endfunction

  always_comb begin
    dx = x_ovf ? '0 : {{3{dx9[8]}}, dx9};
    dy = y_ovf ? '0 : {{3{dy9[8]}}, dy9};
    nx = $signed({2'b00, cursor_x}) + dx;
    // PS/2 reports +y as up; screen rows grow downward.
    ny = $signed({2'b00, cursor_y}) - dy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x <= 10'(X_INIT);
      cursor_y <= 10'(Y_INIT);
    end else if (commit) begin
      cursor_x <= clamp(nx, XM);
      cursor_y <= clamp(ny, YM);
    end
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host sequencer: reset/self-test/enable handshake with retries,
// then 3-byte packet assembly feeding the cursor accumulator.
module ps2_mouse_ctrl
  import mouse_pkg::*;
#(
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned X_INIT       = 320,
  parameter int unsigned Y_INIT       = 240,
  parameter int unsigned RESP_TIMEOUT = 12_500_000,
  parameter int unsigned PKT_GAP      = 50_000,
  parameter int unsigned RETRY_MAX    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_mouse_ctrl_if.master        ps2,
  output logic [9:0]              cursor_x,
  output logic [9:0]              cursor_y,
  output logic [2:0]              btn,
  output logic                    pkt_valid,
  output logic                    ready,
  output logic                    init_fail
);

  localparam int unsigned T_MAX = (RESP_TIMEOUT > PKT_GAP) ? RESP_TIMEOUT : PKT_GAP;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned RW    = $clog2(RETRY_MAX + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [2:0]    hdr_btn;
  logic          hdr_xs, hdr_ys, hdr_xo, hdr_yo;
  logic [7:0]    byte1;
  logic          init_error, gap_abort, commit;

  always_comb begin
    init_error = ps2.tx_err || ps2.rx_err || (timer == TW'(RESP_TIMEOUT)) ||
                 (ps2.rx_valid && (state != ST_EN_SEND) &&
                  (ps2.rx_byte != expected_rsp(state)));
    gap_abort  = ps2.rx_err || (timer == TW'(PKT_GAP));
    commit     = (state == ST_B2) && ps2.rx_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RST_SEND;
      timer        <= '0;
      retry        <= '0;
      ps2.tx_byte  <= '0;
      ps2.tx_start <= 1'b0;
      btn          <= '0;
      pkt_valid    <= 1'b0;
      ready        <= 1'b0;
      init_fail    <= 1'b0;
      hdr_btn      <= '0;
      {hdr_xs, hdr_ys, hdr_xo, hdr_yo} <= '0;
      byte1        <= '0;
    end else begin
      ps2.tx_start <= 1'b0;
      pkt_valid    <= 1'b0;
      case (state)
        ST_RST_SEND: begin
          timer <= '0;
          if (!ps2.tx_busy) begin
            ps2.tx_byte  <= CMD_RESET;
            ps2.tx_start <= 1'b1;
            state        <= ST_RST_ACK;
          end
        end
        ST_RST_ACK, ST_BAT, ST_ID, ST_EN_SEND, ST_EN_ACK: begin
          if (init_error) begin
            timer <= '0;
            retry <= retry + 1'b1;
            if (retry == RW'(RETRY_MAX - 1)) begin
              state     <= ST_FAIL;
              init_fail <= 1'b1;
            end else begin
              state <= ST_RST_SEND;
            end
          end else if (state == ST_EN_SEND) begin
            if (!ps2.tx_busy) begin
              ps2.tx_byte  <= CMD_ENABLE;
              ps2.tx_start <= 1'b1;
              state        <= ST_EN_ACK;
              timer        <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end else if (ps2.rx_valid) begin
            // init_error already rejected a wrong byte, so this one matches.
            timer <= '0;
            case (state)
              ST_RST_ACK: state <= ST_BAT;
              ST_BAT:     state <= ST_ID;
              ST_ID:      state <= ST_EN_SEND;
              default: begin
                state <= ST_B0;
                ready <= 1'b1;
              end
            endcase
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_B0: begin
          timer <= '0;
          if (ps2.rx_valid && ps2.rx_byte[PB_SYNC]) begin
            hdr_btn <= ps2.rx_byte[PB_MIDDLE:PB_LEFT];
            hdr_xs  <= ps2.rx_byte[PB_XSIGN];
            hdr_ys  <= ps2.rx_byte[PB_YSIGN];
            hdr_xo  <= ps2.rx_byte[PB_XOVF];
            hdr_yo  <= ps2.rx_byte[PB_YOVF];
            state   <= ST_B1;
          end
        end
        ST_B1, ST_B2: begin
          if (ps2.rx_valid) begin
            timer <= '0;
            if (state == ST_B1) begin
              byte1 <= ps2.rx_byte;
              state <= ST_B2;
            end else begin
              btn       <= hdr_btn;
              pkt_valid <= 1'b1;
              state     <= ST_B0;
            end
          end else if (gap_abort) begin
            timer <= '0;
            state <= ST_B0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_FAIL: timer <= '0;
        default: state <= ST_RST_SEND;
      endcase
    end
  end

  ps2_cursor_accum #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX),
    .X_INIT(X_INIT),
    .Y_INIT(Y_INIT)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .commit  (commit),
    .dx9     ({hdr_xs, byte1}),
    .dy9     ({hdr_ys, ps2.rx_byte}),
    .x_ovf   (hdr_xo),
    .y_ovf   (hdr_yo),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y)
  );

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: expected commands and packet results
// are queued by the stimulus and checked by a forked monitor.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cursor_x, cursor_y;
  logic [2:0] btn;
  logic       pkt_valid, ready, init_fail;

  always #5 clk = ~clk;

  ps2_mouse_ctrl_if ps2 ();

  ps2_mouse_ctrl #(
    .RESP_TIMEOUT(2000),
    .PKT_GAP     (300)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2      (ps2),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .btn      (btn),
    .pkt_valid(pkt_valid),
    .ready    (ready),
    .init_fail(init_fail)
  );

  // Transceiver stand-in: busy for 30 cycles after each tx_start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (ps2.tx_start) busy_cnt <= 30;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ps2.tx_busy = (busy_cnt != 0);
  assign ps2.tx_err  = 1'b0;

  typedef struct packed {
    logic [2:0] b;
    logic [9:0] x;
    logic [9:0] y;
  } pkt_t;

  pkt_t       pkt_q[$];
  logic [7:0] tx_q[$];
  int         tx_count = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic monitor();
    pkt_t       ep;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (ps2.tx_start) begin
        tx_count++;
        check("tx_while_busy", 32'(ps2.tx_busy), 0);
        if (tx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: got 0x%02h want no command at %0t", ps2.tx_byte, $time);
        end else begin
          eb = tx_q.pop_front();
          check("tx_byte", 32'(ps2.tx_byte), 32'(eb));
        end
      end
      if (pkt_valid) begin
        if (pkt_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pkt_unexpected: got btn=%0d x=%0d y=%0d want no packet at %0t",
                   btn, cursor_x, cursor_y, $time);
        end else begin
          ep = pkt_q.pop_front();
          check("pkt_btn", 32'(btn), 32'(ep.b));
          check("pkt_x", 32'(cursor_x), 32'(ep.x));
          check("pkt_y", 32'(cursor_y), 32'(ep.y));
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2.rx_byte  = b;
    ps2.rx_valid = 1'b1;
    @(negedge clk);
    ps2.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2,
                          input logic [2:0] eb, input int ex, input int ey);
    pkt_q.push_back({eb, 10'(ex), 10'(ey)});
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic wait_tx(input int target, input int budget, output int waited);
    waited = 0;
    while (tx_count < target && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("tx_wait", 32'(tx_count), 32'(target));
  endtask

  task automatic check_reset_vals();
    check("rst_x", 32'(cursor_x), 320);
    check("rst_y", 32'(cursor_y), 240);
    check("rst_btn", 32'(btn), 0);
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_init_fail", 32'(init_fail), 0);
    check("rst_tx_start", 32'(ps2.tx_start), 0);
    check("rst_tx_byte", 32'(ps2.tx_byte), 0);
  endtask

  // Finishes the handshake once the first 0xFF has gone out (tx count = base+1).
  task automatic finish_init(input int base);
    int w;
    repeat (40) @(negedge clk);
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("ready_mid_init", 32'(ready), 0);
    tx_q.push_back(8'hF4);
    send_byte(8'h00);
    wait_tx(base + 2, 200, w);
    repeat (40) @(negedge clk);
    send_byte(8'hFA);
    check("ready_after_init", 32'(ready), 1);
    check("init_fail_after_init", 32'(init_fail), 0);
  endtask

  initial begin
    int base, w;
    rst          = 1'b1;
    ps2.rx_byte  = '0;
    ps2.rx_valid = 1'b0;
    ps2.rx_err   = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Normal bring-up
    base = tx_count;
    tx_q.push_back(8'hFF);
    rst = 1'b0;
    wait_tx(base + 1, 100, w);
    finish_init(base);
    check("init_x", 32'(cursor_x), 320);
    check("init_y", 32'(cursor_y), 240);

    // Left button, dx=+5, dy=-3 (Y sign bit set in byte 0)
    send_pkt(8'h29, 8'h05, 8'hFD, 3'b001, 325, 243);
    // Walk to (2,1): dx=-256 then dx=-67 / dy=+242
    send_pkt(8'h18, 8'h00, 8'h00, 3'b000, 69, 243);
    send_pkt(8'h18, 8'hBD, 8'hF2, 3'b000, 2, 1);
    // dx=-16, dy=-240: x clamps at 0
    send_pkt(8'h38, 8'hF0, 8'h10, 3'b000, 0, 241);
    // Walk to (630,10)
    send_pkt(8'h08, 8'hFF, 8'hE7, 3'b000, 255, 10);
    send_pkt(8'h08, 8'hFF, 8'h00, 3'b000, 510, 10);
    send_pkt(8'h08, 8'h78, 8'h00, 3'b000, 630, 10);
    for (int i = 0; i < 4; i++)
      send_pkt(8'h08, 8'h7F, 8'h7F, 3'b000, 639, 0);
    // dx=-100, dy=-100 -> (539,100)
    send_pkt(8'h38, 8'h9C, 8'h9C, 3'b000, 539, 100);
    // X overflow: dx ignored, y -= 2; then Y overflow: dy ignored
    send_pkt(8'h48, 8'h20, 8'h02, 3'b000, 539, 98);
    send_pkt(8'h88, 8'h10, 8'h50, 3'b000, 555, 98);
    // Stray byte without sync bit, then a good packet
    send_byte(8'h01);
    send_pkt(8'h09, 8'h01, 8'h01, 3'b001, 556, 97);
    // Over-long gap before byte 2 drops the packet; late byte lacks sync
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (400) @(negedge clk);
    send_byte(8'h10);
    send_pkt(8'h0A, 8'h02, 8'h00, 3'b010, 558, 97);
    check("ready_streaming", 32'(ready), 1);

    // Asynchronous reset between byte 1 and byte 2
    send_byte(8'h09);
    send_byte(8'h05);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    base = tx_count;
    tx_q.push_back(8'hFF);
    @(negedge clk);
    rst = 1'b0;
    wait_tx(base + 1, 100, w);
    finish_init(base);
    send_pkt(8'h29, 8'h05, 8'hFD, 3'b001, 325, 243);

    // Three bad self-test replies exhaust the retries
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = tx_count;
    for (int i = 0; i < 3; i++) tx_q.push_back(8'hFF);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_tx(base + i, 200, w);
      if (i == 3) check("init_fail_before_last", 32'(init_fail), 0);
      repeat (40) @(negedge clk);
      send_byte(8'hFA);
      send_byte(8'hFC);
    end
    repeat (200) @(negedge clk);
    check("fail_init_fail", 32'(init_fail), 1);
    check("fail_ready", 32'(ready), 0);
    check("fail_tx_count", 32'(tx_count), 32'(base + 3));

    // Silence in RST_ACK triggers a retry after the response timeout
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = tx_count;
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hFF);
    rst = 1'b0;
    wait_tx(base + 1, 100, w);
    wait_tx(base + 2, 2400, w);
    check("timeout_not_early", 32'(w > 1900), 1);
    finish_init(base + 1);

    repeat (10) @(negedge clk);
    check("pkt_q_drained", 32'(pkt_q.size()), 0);
    check("tx_q_drained", 32'(tx_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
